// File: rtl/instr_mem_loader.sv
// instr_mem_loader: writer side of the program-load port.
// Takes a byte stream ([len_lo][len_hi][word bytes, little-endian]...) over a
// valid/ready handshake, builds DATA_WIDTH-bit words and writes them to
// instruction memory at sequential word addresses. prog_ready is raised once
// every word is stored; load_err flags a length that does not fit.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module instr_mem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  prog_ready,
  output logic                  load_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  // Word counter is one bit wider than the 16-bit length so it can reach len
  // without wrapping even when len == 65535.
  localparam logic [16:0] DEPTH = 17'(MEM_DEPTH);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [16:0]           word_idx;
  logic [BW-1:0]         byte_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_next;
  logic [15:0]           new_len;
  logic                  xfer;
  logic                  last_byte;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  // Incoming bytes enter at the top so that byte 0 ends up in bits [7:0].
  generate
    if (DATA_WIDTH > 8) begin : g_wide
      assign word_next = {byte_data, shreg[DATA_WIDTH-1:8]};
    end else begin : g_narrow
      assign word_next = byte_data;
    end
  endgenerate

  assign new_len   = {byte_data, len_lo};
  assign xfer      = byte_valid & byte_ready;
  assign last_byte = (byte_idx == BW'(BYTES - 1));

  // Ready only in byte-consuming states; start always wins over a transfer.
  always_comb begin
    byte_ready = 1'b0;
    if (!start) begin
      case (state)
        LEN_LO, LEN_HI, DATA: byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        CSUM:                 byte_ready = 1'b1;
`endif
        default:              byte_ready = 1'b0;
      endcase
    end
  end

  // Load FSM with registered write port and status outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      len_lo      <= '0;
      len         <= '0;
      word_idx    <= '0;
      byte_idx    <= '0;
      shreg       <= '0;
      w_en        <= 1'b0;
      w_addr      <= '0;
      instruction <= '0;
      prog_ready  <= 1'b0;
      load_err    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      w_en <= 1'b0;
      if (start) begin
        // Abort anything in flight; a partially assembled word is dropped.
        state      <= LEN_LO;
        prog_ready <= 1'b0;
        load_err   <= 1'b0;
        word_idx   <= '0;
        byte_idx   <= '0;
        shreg      <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum       <= '0;
`endif
      end else begin
        case (state)
          IDLE: ;
          LEN_LO: begin
            if (xfer) begin
              len_lo <= byte_data;
              state  <= LEN_HI;
            end
          end
          LEN_HI: begin
            if (xfer) begin
              len <= new_len;
              if (new_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                state <= CSUM;
`else
                state <= DONE;
`endif
              end else if ({1'b0, new_len} > DEPTH) begin
                state    <= ERR;
                load_err <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
              csum <= csum ^ byte_data;
`endif
              if (last_byte) begin
                byte_idx    <= '0;
                shreg       <= '0;
                w_en        <= 1'b1;
                w_addr      <= word_idx[ADDR_WIDTH-1:0];
                instruction <= word_next;
                word_idx    <= word_idx + 17'd1;
                if ((word_idx + 17'd1) == {1'b0, len}) begin
`ifdef LOADER_CHECKSUM_EN
                  state <= CSUM;
`else
                  state <= DONE;
`endif
                end
              end else begin
                shreg    <= word_next;
                byte_idx <= byte_idx + BW'(1);
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CSUM: begin
            if (xfer) begin
              if (byte_data == csum) begin
                state <= DONE;
              end else begin
                state    <= ERR;
                load_err <= 1'b1;
              end
            end
          end
`endif
          DONE: begin
            // Entered on the edge that raises the final w_en, so this
            // appears one cycle after it.
            prog_ready <= 1'b1;
          end
          ERR: begin
            load_err   <= 1'b1;
            prog_ready <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: the driver derives expected writes
// and final status from the byte stream; a monitor pops and compares writes.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        w_en;
  logic [7:0]  w_addr;
  logic [31:0] instruction;
  logic        prog_ready;
  logic        load_err;

  instr_mem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .MEM_DEPTH(256)) dut (
    .clk(clk), .arst(arst), .start(start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .w_en(w_en),
    .w_addr(w_addr), .instruction(instruction), .prog_ready(prog_ready),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  stim[$];
  int         cycle = 0;
  int         last_wen = -10;
  bit         prev_pr = 1'b0;
  bit         chk_timing = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [39:0] e;
    cycle++;
    if (w_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_w_en: addr %0d data 0x%08h, none expected", w_addr, instruction);
      end else begin
        e = exp_q.pop_front();
        check("w_addr", 64'(w_addr), 64'(e[39:32]));
        check("instruction", 64'(instruction), 64'(e[31:0]));
        $display("write addr=%0d data=0x%08h", w_addr, instruction);
      end
      last_wen = cycle;
    end
    if (prog_ready === 1'b1 && !prev_pr && chk_timing)
      check("prog_ready_delay", 64'(cycle - last_wen), 64'd1);
    prev_pr = (prog_ready === 1'b1);
  end

  // Stream of len random words (plus checksum byte when enabled).
  task automatic build(input int len);
    logic [7:0] x;
    x = 8'h00;
    stim.delete();
    stim.push_back(8'(len));
    stim.push_back(8'(len >> 8));
    for (int i = 0; i < 4 * len; i++) begin
      stim.push_back(8'($urandom));
      x ^= stim[stim.size() - 1];
    end
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(x);
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    if (byte_valid) check("byte_ready_in_start", 64'(byte_ready), 64'd0);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int  n;
    bit  rdy;
    repeat ($urandom_range(0, gapmax)) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    forever begin
      #1;
      rdy = byte_ready;
      @(posedge clk);
      if (rdy) break;
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL byte_timeout: byte_ready stuck 0 sending 0x%02h", b);
        $fatal(1, "handshake timeout");
      end
    end
    @(negedge clk);
  endtask

  // Reference model + driver: sends the first n_send bytes of stim.
  task automatic run_load(input int n_send, input int gapmax);
    int         len;
    bit         exp_err;
    logic [7:0] x;
    len     = {24'd0, stim[1], stim[0]};
    exp_err = (len > 256);
    if (!exp_err) begin
      for (int i = 0; i < len; i++)
        if (2 + 4 * i + 4 <= n_send)
          exp_q.push_back({8'(i), stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
    end
    chk_timing = (len > 0) && !exp_err;
`ifdef LOADER_CHECKSUM_EN
    chk_timing = 1'b0;
    if (!exp_err) begin
      x = 8'h00;
      for (int i = 0; i < 4 * len; i++) x ^= stim[2+i];
      if (stim[2+4*len] != x) exp_err = 1'b1;
    end
`else
    x = 8'h00;
`endif
    $display("load len=%0d bytes=%0d/%0d expect_err=%0d", len, n_send, stim.size(), exp_err);
    pulse_start();
    for (int k = 0; k < n_send; k++) send_byte(stim[k], gapmax);
    byte_valid = 1'b0;
    if (n_send == stim.size()) begin
      repeat (3) @(negedge clk);
      #1;
      check("writes_drained", 64'(exp_q.size()), 64'd0);
      check("prog_ready", 64'(prog_ready), 64'(!exp_err));
      check("load_err", 64'(load_err), 64'(exp_err));
      check("byte_ready_idle", 64'(byte_ready), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_w_en", 64'(w_en), 64'd0);
    check("rst_w_addr", 64'(w_addr), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_prog_ready", 64'(prog_ready), 64'd0);
    check("rst_load_err", 64'(load_err), 64'd0);
    check("rst_byte_ready", 64'(byte_ready), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // Directed two-word program, continuous valid.
    stim = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    stim.push_back(8'h13 ^ 8'h05 ^ 8'hA0 ^ 8'h00 ^ 8'hB3 ^ 8'h05 ^ 8'hB5 ^ 8'h00);
`endif
    run_load(stim.size(), 0);

    // Empty program and oversize program.
    build(0);
    run_load(stim.size(), 0);
    stim = {8'h01, 8'h01};
    run_load(2, 0);

    // Randomized gaps, len=4 and random lengths.
    for (int t = 0; t < 3; t++) begin
      build(4);
      run_load(stim.size(), 3);
    end
    for (int t = 0; t < 4; t++) begin
      build($urandom_range(1, 9));
      run_load(stim.size(), 2);
    end

    // Largest accepted program.
    build(256);
    run_load(stim.size(), 0);

    // Abort after 6 data bytes of len=3, with a byte held across start.
    build(3);
    run_load(8, 1);
    byte_valid = 1'b1;
    byte_data  = stim[8];
    build(1);
    run_load(stim.size(), 1);

`ifdef LOADER_CHECKSUM_EN
    stim = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    run_load(stim.size(), 0);
    stim = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_load(stim.size(), 0);
    build(5);
    stim[stim.size() - 1] = stim[stim.size() - 1] ^ 8'h80;
    run_load(stim.size(), 2);
`endif

    // Reset mid-DATA after two bytes of word 1.
    build(3);
    run_load(8, 0);
    byte_valid = 1'b1;
    byte_data  = stim[8];
    #2 arst = 1'b1;
    #1;
    check("arst_w_en", 64'(w_en), 64'd0);
    check("arst_w_addr", 64'(w_addr), 64'd0);
    check("arst_instruction", 64'(instruction), 64'd0);
    check("arst_prog_ready", 64'(prog_ready), 64'd0);
    check("arst_load_err", 64'(load_err), 64'd0);
    check("arst_byte_ready", 64'(byte_ready), 64'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("post_arst_prog_ready", 64'(prog_ready), 64'd0);
    end
    byte_valid = 1'b0;
    check("post_arst_writes", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the microprocessor program-load port (`prog_ready`, `w_en`, `instruction`).
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at sequential word addresses.
- Asserts `prog_ready` once the whole program is stored, which releases the core to fetch.

Parameters:
- DATA_WIDTH, 32, instruction word width; must be a multiple of 8.
- ADDR_WIDTH, 8, word-address width of instruction memory.
- MEM_DEPTH, 256, maximum number of words accepted; must be ≤ 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a new load and aborts any load in progress.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts byte_data this cycle.
- w_en  out  1  one-cycle instruction-memory write strobe.
- w_addr  out  ADDR_WIDTH  word address for the write.
- instruction  out  DATA_WIDTH  word to write.
- prog_ready  out  1  program fully loaded; the core may run.
- load_err  out  1  length violation (or checksum failure, see Optional Feature).

Behaviour:
- Reset: asynchronous, active-high, one clock; state=IDLE. All outputs 0: byte_ready, w_en, w_addr, instruction, prog_ready, load_err. Internal counters and byte shift register are cleared.
- Handshake: a byte transfers on a rising edge where byte_valid & byte_ready.
  - byte_ready=1 only in LEN_LO, LEN_HI, DATA (and CSUM when enabled).
  - The source may hold byte_valid indefinitely; no bytes are lost or duplicated.
- Stream format: [len_lo][len_hi][word0 b0..b3][word1 b0..b3]...
  - len = {len_hi, len_lo} is a 16-bit word count.
  - Words are little-endian: b0 → instruction[7:0].
- FSM:
  - IDLE: on start → LEN_LO; clear prog_ready, load_err, word index, byte index.
  - LEN_LO: on transfer, latch len[7:0] → LEN_HI.
  - LEN_HI: on transfer, latch len[15:8], then branch:
    - len==0 → DONE.
    - len>MEM_DEPTH → ERR.
    - otherwise → DATA.
  - DATA: each transfer shifts the byte into the assembly register and byte index wraps 0..3. On the 4th byte:
    - Next cycle: w_en=1 for exactly one cycle, with w_addr=word index and instruction=assembled word.
    - Word index increments after the write.
    - When word index reaches len → DONE (→ CSUM if enabled).
  - DONE: prog_ready=1 (registered, first asserted the cycle after the last w_en); byte_ready=0; hold until start or reset.
  - ERR: load_err=1, prog_ready=0, byte_ready=0; no writes; hold until start.
- Latency: last byte of a word → w_en on the next edge (1 cycle). byte_ready stays 1 during the w_en cycle, so back-to-back words stream at 1 byte/cycle.
- w_addr and instruction hold their last written value while w_en=0.
- Boundary conditions:
  - start in any state, including mid-word: partial word discarded, no w_en issued, → LEN_LO. A w_en already scheduled for the same cycle still fires.
  - start coinciding with a byte transfer: start wins and the byte is not consumed. byte_ready is forced 0 in the start cycle.
  - len==MEM_DEPTH: accepted; last write at w_addr=MEM_DEPTH-1.
  - Word index never wraps: ERR prevents len>MEM_DEPTH.
  - Reset mid-load: all state lost; prog_ready=0 until a complete new load.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, FSM enters CSUM and accepts one extra byte.
  - Expected value = XOR of all data bytes (header excluded), accumulated as bytes are accepted.
  - Match → DONE. Mismatch → ERR with load_err=1 and prog_ready=0; words already written stay in memory.
  - len==0 still requires the CSUM byte, and 0x00 matches.
- Undefined: no CSUM state, no accumulator; the stream ends after the last data byte.

Test Plan:
- Reset: assert arst mid-DATA after 2 bytes of word 1 → all outputs 0 immediately; no further w_en; prog_ready stays 0.
- Load len=2: bytes 02 00 13 05 A0 00 B3 05 B5 00 with continuous valid →
  - w_en at addr 0 with 0x00A00513.
  - w_en at addr 1 with 0x00B505B3.
  - prog_ready=1 one cycle after the second w_en.
- Random byte_valid gaps and backpressure on len=4 → exactly 4 w_en pulses, addrs 0..3, data matches the reference model, no duplicate bytes.
- len=0 (00 00) → DONE with no w_en and prog_ready=1. len=257 with MEM_DEPTH=256 (01 01) → load_err=1, no w_en, byte_ready=0.
- Abort: start after 6 data bytes of len=3 → the pending partial word is never written. New stream len=1 writes addr 0, then prog_ready=1.
- LOADER_CHECKSUM_EN: len=1, word bytes 01 02 03 04:
  - CSUM byte 0x04 → prog_ready=1.
  - CSUM byte 0x05 → load_err=1, prog_ready=0, the single w_en still observed.
